// File: rtl/fm_logo_pkg.sv
// Shared types and constants for the FM logo RAM slot front-end.
package fm_logo_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned RAM_AW     = 14;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_LATCH,
    ST_HOLD,
    ST_WR
  } state_t;

  localparam logic [1:0]        PAGE1_SEL     = 2'b01;
  localparam logic [ADDR_W-1:0] REG_LO_ADDR   = 16'h5FFE;
  localparam logic [ADDR_W-1:0] REG_HI_ADDR   = 16'h5FFF;
  localparam logic [DATA_W-1:0] DEF_UNLOCK_LO = 8'h4D;
  localparam logic [DATA_W-1:0] DEF_UNLOCK_HI = 8'h69;
  localparam logic [RAM_AW-1:0] DEF_WR_TOP    = 14'h1FFD;

  // Page 1 is already decoded, so the register window is matched on the RAM offset.
  function automatic logic is_reg_offset(input logic [RAM_AW-1:0] ofs);
    return (ofs == REG_LO_ADDR[RAM_AW-1:0]) || (ofs == REG_HI_ADDR[RAM_AW-1:0]);
  endfunction

endpackage

// File: rtl/fm_logo_unlock_regs.sv
// Two write-unlock registers at 0x5FFE/0x5FFF with read mux and unlocked flag.
module fm_logo_unlock_regs
  import fm_logo_pkg::*;
#(
  parameter logic [7:0] UNLOCK_LO = DEF_UNLOCK_LO,
  parameter logic [7:0] UNLOCK_HI = DEF_UNLOCK_HI
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       sel,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data_c,
  output logic       unlocked_c
);

  logic [7:0] reg_lo;
  logic [7:0] reg_hi;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      reg_lo <= 8'h00;
      reg_hi <= 8'h00;
    end else if (wr_en) begin
      if (sel) reg_hi <= wr_data;
      else     reg_lo <= wr_data;
    end
  end

  assign rd_data_c  = sel ? reg_hi : reg_lo;
  assign unlocked_c = (reg_lo == UNLOCK_LO) && (reg_hi == UNLOCK_HI);

endmodule

// File: rtl/fm_logo_slot.sv
// Z80 page-1 slot front-end for the FM logo RAM: wait-state insertion and write unlock gating.
module fm_logo_slot
  import fm_logo_pkg::*;
#(
  parameter logic [7:0]  UNLOCK_LO = DEF_UNLOCK_LO,
  parameter logic [7:0]  UNLOCK_HI = DEF_UNLOCK_HI,
  parameter logic [13:0] WR_TOP    = DEF_WR_TOP
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs,
  input  logic [15:0] addr,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic [13:0] ram_address,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  input  logic [7:0]  ram_q
);

  state_t      state;
  state_t      state_nx;
  logic        wait_n_nx;
  logic        data_oe_nx;
  logic [7:0]  data_out_nx;
  logic [13:0] ram_address_nx;
  logic [7:0]  ram_data_nx;
  logic        ram_wren_nx;
  logic        reg_we_c;
  logic        reg_hit_c;
  logic        access_c;
  logic        rd_req_c;
  logic        wr_req_c;
  logic [7:0]  reg_rd_c;
  logic        unlocked_c;

  // Both strobes low is not an access.
  assign access_c  = cs && !mreq_n && (addr[15:14] == PAGE1_SEL) && (rd_n ^ wr_n);
  assign rd_req_c  = access_c && !rd_n;
  assign wr_req_c  = access_c && !wr_n;
  assign reg_hit_c = is_reg_offset(ram_address);

  fm_logo_unlock_regs #(
    .UNLOCK_LO (UNLOCK_LO),
    .UNLOCK_HI (UNLOCK_HI)
  ) u_unlock_regs (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (reg_we_c),
    .sel        (ram_address[0]),
    .wr_data    (ram_data),
    .rd_data_c  (reg_rd_c),
    .unlocked_c (unlocked_c)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_n      <= 1'b1;
      data_oe     <= 1'b0;
      data_out    <= 8'hFF;
      ram_address <= 14'h0000;
      ram_data    <= 8'h00;
      ram_wren    <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_n      <= wait_n_nx;
      data_oe     <= data_oe_nx;
      data_out    <= data_out_nx;
      ram_address <= ram_address_nx;
      ram_data    <= ram_data_nx;
      ram_wren    <= ram_wren_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    wait_n_nx      = wait_n;
    data_oe_nx     = data_oe;
    data_out_nx    = data_out;
    ram_address_nx = ram_address;
    ram_data_nx    = ram_data;
    ram_wren_nx    = 1'b0;
    reg_we_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req_c) begin
          ram_address_nx = addr[13:0];
          wait_n_nx      = 1'b0;
          state_nx       = ST_RD_ADDR;
        end else if (wr_req_c) begin
          ram_address_nx = addr[13:0];
          ram_data_nx    = data_in;
          state_nx       = ST_WR;
        end
      end
      ST_RD_ADDR: state_nx = ST_RD_LATCH;
      ST_RD_LATCH: begin
        data_out_nx = reg_hit_c ? reg_rd_c : ram_q;
        data_oe_nx  = 1'b1;
        wait_n_nx   = 1'b1;
        state_nx    = ST_HOLD;
      end
      ST_WR: begin
        if (reg_hit_c) reg_we_c = 1'b1;
        else if (unlocked_c && (ram_address <= WR_TOP)) ram_wren_nx = 1'b1;
        state_nx = ST_HOLD;
      end
      // One action per bus cycle: wait for the strobe or select to go away.
      ST_HOLD: begin
        if (mreq_n || !cs) begin
          data_oe_nx  = 1'b0;
          data_out_nx = 8'hFF;
          state_nx    = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: doc/fm_logo_slot.md
# fm_logo_slot

Z80-bus slot front-end for the 16 KB FM logo RAM (14-bit address, one-cycle registered read). It decodes cartridge accesses in page 1 (0x4000–0x7FFF) and inserts a wait state to cover the RAM read latency. It also gates writes through the FM-PAC style unlock registers at 0x5FFE/0x5FFF and drives the RAM's address, data and write-enable ports.

## Interface
Parameters:
- UNLOCK_LO, 8'h4D, value required at 0x5FFE to enable writes
- UNLOCK_HI, 8'h69, value required at 0x5FFF to enable writes
- WR_TOP, 14'h1FFD, highest RAM offset writable when unlocked

Ports:
- clock  in  1  system clock; all bus inputs are synchronous to it
- reset_n  in  1  synchronous, active-low reset
- cs  in  1  slot select from the slot decoder, active high
- addr  in  16  Z80 address
- mreq_n  in  1  memory request, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- data_in  in  8  Z80 write data
- data_out  out  8  read data to the bus
- data_oe  out  1  drive enable for data_out
- wait_n  out  1  Z80 WAIT, active low
- ram_address  out  14  to the RAM address port
- ram_data  out  8  to the RAM data port
- ram_wren  out  1  to the RAM write enable, one-cycle pulse
- ram_q  in  8  from the RAM q output, valid one cycle after the address is sampled

## Operation
- An access is valid when cs=1, mreq_n=0, addr[15:14]=2'b01 and exactly one of rd_n or wr_n is 0. Both strobes low means no access: no wait, no write.
- The FSM has five states: IDLE, RD_ADDR, RD_LATCH, HOLD, WR.
- In IDLE, a valid read:
  - registers ram_address=addr[13:0];
  - drives wait_n=0;
  - moves to RD_ADDR.
- RD_ADDR lets the RAM sample the address, then moves to RD_LATCH.
- RD_LATCH:
  - for addr 0x5FFE/0x5FFF, loads data_out from the register file; otherwise from ram_q;
  - sets data_oe=1 and wait_n=1;
  - moves to HOLD.
- In IDLE, a valid write:
  - registers ram_address and ram_data=data_in;
  - moves to WR.
- WR:
  - for addr 0x5FFE/0x5FFF, updates the register;
  - otherwise pulses ram_wren=1 for one cycle, only if unlocked and ram_address ≤ WR_TOP;
  - moves to HOLD.
- Writes take no wait states.
- HOLD waits until mreq_n=1 or cs=0. It then clears data_oe, sets data_out=8'hFF and returns to IDLE. This is one action per bus cycle and prevents re-triggering.
- Unlocked = (reg_5ffe==UNLOCK_LO) && (reg_5fff==UNLOCK_HI). It is evaluated at the time of the WR cycle.
- Writes to 0x5FFE/0x5FFF never reach the RAM. Reads of them return the register values.
- Reads of the RAM are always allowed, including offsets above WR_TOP.

## Timing
- Reset values (reset_n=0 at a clock edge):
  - state=IDLE;
  - wait_n=1, data_oe=0, data_out=8'hFF;
  - ram_wren=0, ram_address=0, ram_data=0;
  - both unlock registers=0 (locked).
- Read, with detection edge D:
  - wait_n low from after D until after D+2;
  - data_out/data_oe valid after D+2;
  - 2 wait cycles.
- Write, with detection edge D:
  - ram_wren high between edges D+1 and D+2;
  - address and data stable from D to D+2.
- Reset during any state:
  - abandons the access at that edge;
  - releases wait_n;
  - discards any pending ram_wren;
  - clears the unlock registers.
- cs dropping mid-read (RD_ADDR/RD_LATCH): the sequence completes, then HOLD exits immediately because cs=0.
- Back-to-back accesses are accepted only after returning to IDLE, so there is at least one IDLE cycle between accesses.

## Structure
- Shared package fm_logo_pkg holds:
  - the state enum;
  - page-1 decode constants;
  - register addresses 16'h5FFE and 16'h5FFF;
  - the default unlock magic values.
- One sub-module is natural: fm_logo_unlock_regs. It contains the two 8-bit registers, the write port, the read mux and the unlocked flag.
- The FSM and bus datapath live in the top module.

## Test plan
- Read 0x4123 with RAM[0x0123]=0xA5 → wait_n low for exactly 2 cycles; data_out=0xA5 with data_oe=1; ram_address=0x0123.
- Write 0x3C to 0x4010 while locked → no ram_wren pulse; a following read of 0x4010 returns the original contents.
- Write 0x4D→0x5FFE, then 0x69→0x5FFF, then 0x3C→0x4010 → one ram_wren pulse with ram_address=0x0010 and ram_data=0x3C; a read-back gives 0x3C; a read of 0x5FFF gives 0x69.
- While unlocked, write to 0x5FFE+offset region 0x7000 (RAM offset 0x3000 > WR_TOP) → no ram_wren; 0x5FFE reads 0x4D.
- cs=0, or addr=0x8000, or rd_n=wr_n=0 with mreq_n=0 → wait_n stays 1, data_oe stays 0, ram_wren stays 0.
- Assert reset_n=0 in RD_ADDR → next edge: wait_n=1, data_oe=0, data_out=0xFF, unlock registers cleared (a subsequent write to 0x4010 is ignored).
